// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with an anti-ghost blanking gap,
// PWM brightness, per-digit blink/blank and frame-synchronous double-buffered data.
module seg_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int SLOT_CYCLES  = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] codes,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   seg_selector,
    output logic [7:0]            segments,
    output logic                  frame_start
);
    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam int DIG_W  = $clog2(N_DIGITS);
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [4*N_DIGITS-1:0] codes;
        logic [N_DIGITS-1:0]   dp;
        logic [N_DIGITS-1:0]   en;
        logic [N_DIGITS-1:0]   blink;
    } disp_t;

    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]    digit_idx_q, digit_idx_d;
    logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    disp_t               shadow_q, shadow_d;
    disp_t               active_q, active_d;
    logic                pending_q, pending_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_start_q, frame_start_d;

    disp_t      live;
    logic       slot_wrap;
    logic       frame_end;
    logic       pwm_on;
    logic       lit;
    logic [3:0] cur_code;

    function automatic logic [7:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    glyph = 8'b00000011;
            4'd1:    glyph = 8'b10011111;
            4'd2:    glyph = 8'b00100101;
            4'd3:    glyph = 8'b00001101;
            4'd4:    glyph = 8'b10011001;
            4'd5:    glyph = 8'b01001001;
            4'd6:    glyph = 8'b01000001;
            4'd7:    glyph = 8'b00011111;
            4'd8:    glyph = 8'b00000001;
            4'd9:    glyph = 8'b00001001;
            4'd10:   glyph = 8'b00010001;
            4'd11:   glyph = 8'b11000001;
            4'd12:   glyph = 8'b01100011;
            4'd13:   glyph = 8'b00110001;
            4'd14:   glyph = 8'b01001001;
            default: glyph = 8'b11111101;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        live.codes    = codes;
        live.dp       = dp;
        live.en       = digit_en;
        live.blink    = blink_mask;
        slot_wrap     = (slot_cnt_q == SLOT_W'(SLOT_CYCLES - 1));
        frame_end     = slot_wrap && (digit_idx_q == DIG_W'(N_DIGITS - 1));
        slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
        digit_idx_d   = digit_idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        frame_start_d = frame_end;

        if (slot_wrap) begin
            digit_idx_d = frame_end ? '0 : digit_idx_q + DIG_W'(1);
        end

        // The active set only changes on a frame boundary; a load landing on that
        // very cycle bypasses the shadow so it is not lost.
        if (frame_end) begin
            if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRM_W'(1);
            end
            if (load) begin
                active_d = live;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = live;
            pending_d = 1'b1;
        end

        cur_code = active_q.codes[{digit_idx_q, 2'b00} +: 4];
        pwm_on   = (&brightness) || (slot_cnt_q[BRIGHT_W-1:0] < brightness);
        lit      = (slot_cnt_q >= SLOT_W'(BLANK_CYCLES))
                   && active_q.en[digit_idx_q]
                   && !(active_q.blink[digit_idx_q] && blink_phase_q)
                   && pwm_on;

        sel_d = '1;
        seg_d = 8'hFF;
        if (lit) begin
            sel_d[digit_idx_q] = 1'b0;
            seg_d = glyph(cur_code) & ~{7'b0, active_q.dp[digit_idx_q]};
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            sel_q         <= '1;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_selector = sel_q;
    assign segments     = seg_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised self-checking bench for seg_scan_driver against a frame-level reference
// model: each frame shows the data of the last load seen during the previous frame.
module tb_seg_scan_driver;
    localparam int N_DIGITS     = 4;
    localparam int SLOT_CYCLES  = 32;
    localparam int BLANK_CYCLES = 4;
    localparam int BRIGHT_W     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYCLES = N_DIGITS * SLOT_CYCLES;

    localparam logic [7:0] GLYPH [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b00110001, 8'b01001001, 8'b11111101
    };

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [4*N_DIGITS-1:0] codes = '0;
    logic [N_DIGITS-1:0]   dp = '0;
    logic [N_DIGITS-1:0]   digit_en = '0;
    logic [N_DIGITS-1:0]   blink_mask = '0;
    logic [BRIGHT_W-1:0]   brightness = '0;
    logic                  load = 1'b0;
    logic [N_DIGITS-1:0]   seg_selector;
    logic [7:0]            segments;
    logic                  frame_start;

    seg_scan_driver #(
        .N_DIGITS    (N_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES),
        .BRIGHT_W    (BRIGHT_W),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .codes       (codes),
        .dp          (dp),
        .digit_en    (digit_en),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .load        (load),
        .seg_selector(seg_selector),
        .segments    (segments),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycle index since reset, displayed set, and the latest load of this frame.
    int                    mt = 0;
    logic [4*N_DIGITS-1:0] act_codes = '0;
    logic [N_DIGITS-1:0]   act_dp = '0;
    logic [N_DIGITS-1:0]   act_en = '0;
    logic [N_DIGITS-1:0]   act_blink = '0;
    logic [4*N_DIGITS-1:0] nxt_codes = '0;
    logic [N_DIGITS-1:0]   nxt_dp = '0;
    logic [N_DIGITS-1:0]   nxt_en = '0;
    logic [N_DIGITS-1:0]   nxt_blink = '0;
    bit                    nxt_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, time %0t)", tag, got, exp, mt, $time);
        end
    endtask

    task automatic tick();
        logic [N_DIGITS-1:0] exp_sel;
        logic [7:0]          exp_seg;
        logic                exp_fs;
        int                  slot;
        int                  dig;
        int                  frame;
        bit                  phase;
        bit                  pwm;
        bit                  lit;
        exp_sel = '1;
        exp_seg = 8'hFF;
        exp_fs  = 1'b0;
        if (rst) begin
            mt        = 0;
            act_codes = '0;
            act_dp    = '0;
            act_en    = '0;
            act_blink = '0;
            nxt_valid = 1'b0;
        end else begin
            slot  = mt % SLOT_CYCLES;
            dig   = (mt / SLOT_CYCLES) % N_DIGITS;
            frame = mt / FRAME_CYCLES;
            phase = ((frame / BLINK_FRAMES) % 2) == 1;
            pwm   = (int'(brightness) == (1 << BRIGHT_W) - 1)
                    || ((slot % (1 << BRIGHT_W)) < int'(brightness));
            lit   = (slot >= BLANK_CYCLES) && act_en[dig]
                    && !(act_blink[dig] && phase) && pwm;
            if (lit) begin
                exp_sel[dig] = 1'b0;
                exp_seg      = GLYPH[act_codes[4*dig +: 4]];
                if (act_dp[dig]) exp_seg[0] = 1'b0;
            end
            if (load) begin
                nxt_codes = codes;
                nxt_dp    = dp;
                nxt_en    = digit_en;
                nxt_blink = blink_mask;
                nxt_valid = 1'b1;
            end
            mt++;
            exp_fs = ((mt % FRAME_CYCLES) == 0);
            if (exp_fs && nxt_valid) begin
                act_codes = nxt_codes;
                act_dp    = nxt_dp;
                act_en    = nxt_en;
                act_blink = nxt_blink;
                nxt_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("seg_selector", 32'(seg_selector), 32'(exp_sel));
        check("segments", 32'(segments), 32'(exp_seg));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("one_selector_low", 32'($countones(~seg_selector) <= 1), 32'(1));
        if (seg_selector == '1) check("dark_segments", 32'(segments), 32'hFF);
    endtask

    task automatic scramble();
        codes      = 16'($urandom);
        dp         = 4'($urandom);
        digit_en   = 4'($urandom);
        blink_mask = 4'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            scramble();
            tick();
        end
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME_CYCLES && (mt % FRAME_CYCLES) != pos; i++) begin
            scramble();
            tick();
        end
    endtask

    task automatic do_load(input logic [15:0] c, input logic [3:0] d, input logic [3:0] e,
                           input logic [3:0] b);
        codes      = c;
        dp         = d;
        digit_en   = e;
        blink_mask = b;
        load       = 1'b1;
        tick();
        load       = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset and no load: stays dark, frame_start every FRAME_CYCLES.
        brightness = 2'b11;
        apply_reset(3);
        run(300);

        // First load in frame 0 appears from frame 1.
        apply_reset(2);
        run(10);
        do_load(16'h3210, 4'h0, 4'hF, 4'h0);
        run(3 * FRAME_CYCLES);

        // PWM duty: 1-of-4, dark, 2-of-4.
        brightness = 2'b01;
        run(FRAME_CYCLES);
        brightness = 2'b00;
        run(FRAME_CYCLES);
        brightness = 2'b10;
        run(FRAME_CYCLES);

        // Blink on digit 1 with random glyphs and decimal points.
        brightness = 2'b11;
        do_load(16'($urandom), 4'($urandom), 4'hF, 4'b0010);
        run(5 * FRAME_CYCLES);

        // Two loads in one frame, then a third on the frame-boundary cycle.
        run_to(10);
        do_load(16'h5555, 4'h0, 4'hF, 4'h0);
        run(20);
        do_load(16'h9999, 4'h1, 4'hF, 4'h0);
        run_to(FRAME_CYCLES - 1);
        do_load(16'hCCCC, 4'h0, 4'hF, 4'h0);
        run(2 * FRAME_CYCLES);

        // Reset mid-slot with digit 2 lit and a load pending.
        do_load(16'h8421, 4'h4, 4'hF, 4'h0);
        run_to(0);
        run_to(2 * SLOT_CYCLES + 10);
        do_load(16'hABCD, 4'hF, 4'hF, 4'h0);
        run(1);
        apply_reset(1);
        run(2 * FRAME_CYCLES);
        do_load(16'h7E6D, 4'h2, 4'hB, 4'h0);
        run(2 * FRAME_CYCLES);

        // Randomised traffic: sparse loads anywhere, brightness changes.
        for (int i = 0; i < 3000; i++) begin
            scramble();
            if ($urandom_range(0, 49) == 0) brightness = 2'($urandom);
            load = ($urandom_range(0, 99) == 0);
            tick();
            load = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised time-multiplexed driver for common-anode 7-segment displays (active-low selectors and segments), the next generation of the elevator display scanner.
- Adds a configurable digit count, an anti-ghost blanking gap, PWM brightness, per-digit blink and blank, and frame-synchronous double-buffered display data.
- Sits between the elevator status logic, which supplies glyph codes, and the board display pins.

Parameters:
- N_DIGITS, 4: number of multiplexed digits, at least 2.
- SLOT_CYCLES, 65536: clk cycles per digit slot. Must be a multiple of 2**BRIGHT_W and greater than BLANK_CYCLES.
- BLANK_CYCLES, 256: cycles at the start of each slot with all selectors off.
- BRIGHT_W, 4: width of the brightness input.
- BLINK_FRAMES, 64: frames per blink half-period.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- codes  in  4*N_DIGITS  glyph code per digit; digit i uses bits [4i+3:4i]
- dp  in  N_DIGITS  decimal point per digit, 1 = lit
- digit_en  in  N_DIGITS  1 = digit shown, 0 = blank
- blink_mask  in  N_DIGITS  1 = digit blinks
- brightness  in  BRIGHT_W  PWM duty
- load  in  1  strobe that captures codes, dp, digit_en and blink_mask into the shadow register
- seg_selector  out  N_DIGITS  active-low digit enables; bit 0 = digit 0
- segments  out  8  active-low; bit7..bit0 = a,b,c,d,e,f,g,dp
- frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (synchronous, active-high; applies mid-frame):
  - seg_selector = all ones, segments = 8'hFF, frame_start = 0.
  - slot_cnt = 0, digit_idx = 0, frame_cnt = 0, blink_phase = 0.
  - Shadow and active registers cleared, so digit_en = 0 and everything is blank until the first load reaches the active set.
  - No pending load survives reset.
- Counters:
  - slot_cnt runs 0..SLOT_CYCLES-1 and wraps.
  - On wrap, digit_idx increments modulo N_DIGITS.
  - A frame boundary is the cycle where slot_cnt wraps and digit_idx goes from N_DIGITS-1 to 0.
- Frame boundary actions:
  - frame_cnt increments. When it reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
  - frame_start is asserted for exactly the next cycle.
  - If load is asserted in that same cycle, the active set takes the live inputs (bypass). Otherwise it takes the shadow register, but only if a load is pending.
  - The pending flag clears.
- Load outside a frame boundary:
  - Overwrites the shadow register and sets pending; the last load in a frame wins.
  - The active set is never changed mid-frame, so no tearing.
- Per-cycle drive decision, for d = digit_idx:
  - lit = (slot_cnt >= BLANK_CYCLES) and active digit_en[d] and not (active blink_mask[d] and blink_phase) and pwm_on.
  - pwm_on = (slot_cnt[BRIGHT_W-1:0] < brightness), or brightness all ones, which means always on.
  - brightness = 0 means dark.
  - brightness is sampled live, not buffered.
- Outputs, registered with 1 cycle latency from counter state:
  - seg_selector = ~(lit << d).
  - segments = glyph(code[d]) with bit0 cleared if active dp[d]. When not lit, 8'hFF.
- Glyph table (code -> segments, dp off):
  - 0 -> 00000011
  - 1 -> 10011111
  - 2 -> 00100101
  - 3 -> 00001101
  - 4 -> 10011001
  - 5 -> 01001001
  - 6 -> 01000001
  - 7 -> 00011111
  - 8 -> 00000001
  - 9 -> 00001001
  - 10 (A) -> 00010001
  - 11 (b) -> 11000001
  - 12 (C) -> 01100011
  - 13 (P) -> 00110001
  - 14 (S) -> 01001001
  - 15 (-) -> 11111101
- Invariants:
  - At most one seg_selector bit is low in any cycle.
  - When no selector bit is low, segments = 8'hFF.

Test Plan:
Bench parameters for all scenarios: N_DIGITS=4, SLOT_CYCLES=32, BLANK_CYCLES=4, BRIGHT_W=2, BLINK_FRAMES=2.
1. Reset, no load, 300 cycles -> seg_selector stays 4'hF and segments stays 8'hFF throughout; frame_start pulses every 128 cycles.
2. load codes={3,2,1,0}, digit_en=4'hF, brightness=2'b11 during frame 0 -> frame 0 stays dark; from frame 1, digit 0 shows 00000011 with selector 1110, then 1101/10011111, 1011/00100101, 0111/00001101; selector 1111 for the first 4 cycles of each slot.
3. brightness=2'b01 -> within the lit region of each slot, the selector is low only when slot_cnt[1:0]==0, i.e. a 1-of-4 duty; brightness=0 -> fully dark.
4. blink_mask=4'b0010 -> digit 1 lit for 2 frames, dark for 2 frames, repeating; other digits unaffected.
5. Two loads in one frame (codes 5 then 9), plus a third load coincident with the frame boundary (code 12) -> the next frame shows 12; no mixed frame ever appears.
6. rst asserted mid-slot with digit 2 lit -> the next cycle shows selector 4'hF and segments 8'hFF; the pending load is discarded and the display stays blank until the next load.
